pipe_buffer: RTL and testbench
==============================

# pipe_buffer

Parametrised elastic pipeline-stage buffer that carries one WIDTH-bit payload per transfer between two processor stages, such as the decode→execute or execute→memory boundary. It replaces fixed single-register stage latches with a DEPTH-entry FIFO. It uses valid/ready handshakes on both sides, a global stage-enable (WE) for stalls, and a synchronous flush for branch/exception squash. Throughput is one transfer per cycle on each side; first-word latency is one cycle.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 2, number of storage entries; power of two, ≥2
- ref_clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- WE  in  1  stage enable; 0 freezes all transfers (stall)
- flush  in  1  synchronous squash of all stored entries
- in_valid  in  1  upstream presents DataI
- in_ready  out  1  buffer can accept a push this cycle
- DataI  in  WIDTH  upstream payload
- out_valid  out  1  DataO holds a valid head entry
- out_ready  in  1  downstream consumes head this cycle
- DataO  out  WIDTH  head-of-buffer payload
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr and read pointer rd_ptr of $clog2(DEPTH) bits. Pointers wrap naturally modulo DEPTH. count tracks occupancy 0..DEPTH.
- in_ready = WE & (count != DEPTH) & ~flush.
- out_valid = WE & (count != 0) & ~flush.
- push = in_valid & in_ready: writes DataI to mem[wr_ptr] and increments wr_ptr.
- pop = out_valid & out_ready: increments rd_ptr.
- count update: +1 on push only, −1 on pop only, unchanged on push&pop together or on neither.
- No combinational pass-through. A push into an empty buffer is not visible on DataO until the next cycle. When full, in_ready=0 even if a pop happens in the same cycle.
- DataO = mem[rd_ptr] when count != 0, else all-zeros. It depends only on state, not on the WE/flush inputs.
- WE=0: no push, no pop. Pointers, count and storage hold. DataO keeps its value. in_ready and out_valid are forced to 0.
- flush=1 at an edge: wr_ptr, rd_ptr and count go to 0, and any push or pop in that cycle is discarded. Storage contents are not cleared, but they become invisible because DataO reads as 0. flush takes priority over WE.
- Upstream protocol: once in_valid is asserted, DataI must stay stable until accepted. The buffer does not check this.

## Timing
- Reset (rst_n=0, asynchronous, immediate): wr_ptr=0, rd_ptr=0, count=0, all storage entries=0. Outputs: in_ready=WE&~flush, out_valid=0, DataO=0, count=0.
- Release of rst_n is synchronised externally. The first push may occur at the first rising edge after release.
- Latency: a push at edge k gives out_valid=1 and DataO=pushed word in the cycle after edge k.
- Sustained throughput: 1 push and 1 pop per cycle with any count between 1 and DEPTH−1.
- Full (count=DEPTH): in_ready=0. A pop at edge k raises in_ready in the cycle after k.
- Empty: out_valid=0. out_ready is ignored.
- Reset during activity: all entries are lost immediately. A push being presented at assertion is not captured.
- Simultaneous flush and push: the push is dropped, and count=0 after the edge.

## Test plan
- Reset then single push. Hold rst_n=0 for 2 cycles with DataI=0x7FF and in_valid=1: out_valid=0, DataO=0, count=0. Release rst_n and keep WE=1, out_ready=0. After the next edge: count=1, out_valid=1, DataO=0x000007FF.
- Fill/full/drain with DEPTH=2. Push 0x1 then 0x2 with out_ready=0: count=2 and in_ready=0, and a third push of 0x3 is refused. Set out_ready=1: DataO reads 0x1 then 0x2, then count=0 and DataO=0.
- Streaming and wrap-around. Push 0x10..0x17 back-to-back with out_ready=1 from the cycle after the first push: DataO shows 0x10..0x17 in order, one per cycle, count stays at 1, and the pointers wrap 4 times with no loss.
- Stall. With 0x5 stored, drop WE for 3 cycles while in_valid=out_ready=1: in_ready=0, out_valid=0, count=1 and DataO=0x5 throughout. When WE returns, 0x5 pops first.
- Flush. With count=2 (0xA, 0xB), assert flush together with a push of 0xC: after the edge count=0, DataO=0, out_valid=0. Pushing 0xD next gives DataO=0xD.
- Async reset mid-stream. Assert rst_n=0 between edges while count=2: count, DataO and out_valid go to 0 before the next edge, and a push presented during reset is not captured.

Source files
------------

// File: rtl/pipe_buffer.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO with valid/ready handshakes,
// a global stage enable for stalls and a synchronous flush for squashes.
module pipe_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       ref_clk,
   input  logic                       rst_n,
   input  logic                       WE,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           DataI,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           DataO,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // Full blocks pushes even when a pop is happening: no same-cycle slot reuse.
   assign in_ready  = WE & ~w_full  & ~flush;
   assign out_valid = WE & ~w_empty & ~flush;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign DataO = w_empty ? '0 : r_mem[r_rd_ptr];
   assign count = r_count;

   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         // Storage is left as is; it becomes unreachable once count is zero.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= DataI;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_buffer.sv
// Self-checking bench for pipe_buffer: reset, vector table, streaming,
// async reset mid-stream, and randomized traffic against a queue model.
module tb_pipe_buffer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             ref_clk = 1'b0;
   logic             rst_n;
   logic             WE;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] DataI;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] DataO;
   logic [CW-1:0]    count;

   int n_checks = 0;
   int n_errors = 0;

   pipe_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .ref_clk  (ref_clk),
      .rst_n    (rst_n),
      .WE       (WE),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .DataI    (DataI),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .DataO    (DataO),
      .count    (count)
   );

   always #5 ref_clk = ~ref_clk;

   typedef struct {
      logic [3:0]       ctl;    // {WE, flush, in_valid, out_ready}
      logic [WIDTH-1:0] din;
      logic [1:0]       eflg;   // {in_ready, out_valid}
      logic [WIDTH-1:0] edo;
      int               ecnt;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] ctl, input logic [WIDTH-1:0] din,
                               input logic [1:0] eflg, input logic [WIDTH-1:0] edo,
                               input int ecnt);
      vec_t v;
      v.ctl = ctl; v.din = din; v.eflg = eflg; v.edo = edo; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic eir, input logic eov,
                          input logic [WIDTH-1:0] edo, input int ecnt);
      chk({tag, ".in_ready"},  WIDTH'(in_ready),  WIDTH'(eir));
      chk({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(eov));
      chk({tag, ".DataO"},     DataO,             edo);
      chk({tag, ".count"},     WIDTH'(count),     WIDTH'(ecnt));
   endtask

   // Advance one edge, then give outputs time to settle away from it.
   task automatic tick();
      @(posedge ref_clk);
      #1;
   endtask

   vec_t vecs[17];

   // Reference model: plain FIFO queue.
   logic [WIDTH-1:0] q[$];

   initial begin
      rst_n = 1'b0; WE = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      DataI = 32'h7FF;

      // Reset with a push presented: nothing captured.
      tick(); tick();
      #1 chk_all("reset", 1'b1, 1'b0, '0, 0);
      @(negedge ref_clk);
      rst_n = 1'b1;
      tick();
      chk_all("first_push", 1'b1, 1'b1, 32'h7FF, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1 chk("drain_7ff.count", WIDTH'(count), 0);

      // Fill/full/drain, stall, flush.
      vecs[0]  = mk(4'b1010, 32'h1, 2'b10, 32'h0, 0);
      vecs[1]  = mk(4'b1010, 32'h2, 2'b11, 32'h1, 1);
      vecs[2]  = mk(4'b1010, 32'h3, 2'b01, 32'h1, 2);
      vecs[3]  = mk(4'b1011, 32'h3, 2'b01, 32'h1, 2);
      vecs[4]  = mk(4'b1001, 32'h0, 2'b11, 32'h2, 1);
      vecs[5]  = mk(4'b1001, 32'h0, 2'b10, 32'h0, 0);
      vecs[6]  = mk(4'b1010, 32'h5, 2'b10, 32'h0, 0);
      vecs[7]  = mk(4'b0011, 32'h6, 2'b00, 32'h5, 1);
      vecs[8]  = mk(4'b0011, 32'h6, 2'b00, 32'h5, 1);
      vecs[9]  = mk(4'b0011, 32'h6, 2'b00, 32'h5, 1);
      vecs[10] = mk(4'b1001, 32'h0, 2'b11, 32'h5, 1);
      vecs[11] = mk(4'b1010, 32'hA, 2'b10, 32'h0, 0);
      vecs[12] = mk(4'b1010, 32'hB, 2'b11, 32'hA, 1);
      vecs[13] = mk(4'b1110, 32'hC, 2'b00, 32'hA, 2);
      vecs[14] = mk(4'b1010, 32'hD, 2'b10, 32'h0, 0);
      vecs[15] = mk(4'b1001, 32'h0, 2'b11, 32'hD, 1);
      vecs[16] = mk(4'b1000, 32'h0, 2'b10, 32'h0, 0);

      for (int i = 0; i < 17; i++) begin
         {WE, flush, in_valid, out_ready} = vecs[i].ctl;
         DataI = vecs[i].din;
         #1 chk_all($sformatf("vec%0d", i), vecs[i].eflg[1], vecs[i].eflg[0],
                    vecs[i].edo, vecs[i].ecnt);
         tick();
      end

      // Streaming 0x10..0x17 with wrap-around.
      WE = 1'b1; flush = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         in_valid  = (i < 8);
         DataI     = 32'h10 + WIDTH'(i);
         out_ready = (i >= 1);
         #1;
         if (i >= 1) begin
            chk($sformatf("stream%0d.DataO", i), DataO, 32'h10 + WIDTH'(i - 1));
            chk($sformatf("stream%0d.count", i), WIDTH'(count), 1);
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      #1 chk("stream_end.count", WIDTH'(count), 0);

      // Async reset mid-stream with count=2.
      in_valid = 1'b1; DataI = 32'h21; tick();
      DataI = 32'h22; tick();
      in_valid = 1'b0;
      #1 chk("pre_rst.count", WIDTH'(count), 2);
      @(negedge ref_clk);
      rst_n = 1'b0; in_valid = 1'b1; DataI = 32'h99;
      #1 chk_all("async_rst", 1'b1, 1'b0, '0, 0);
      tick();
      @(negedge ref_clk);
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      chk_all("post_rst", 1'b1, 1'b0, '0, 0);

      // Randomized traffic against the queue model (starts empty).
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic m_ir, m_ov;
         logic [WIDTH-1:0] m_do;
         WE        = ($urandom_range(0, 9) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_valid  = $urandom_range(0, 1) == 1;
         out_ready = $urandom_range(0, 2) != 0;
         DataI     = $urandom;
         #1;
         m_ir = WE && !flush && (q.size() < DEPTH);
         m_ov = WE && !flush && (q.size() > 0);
         m_do = (q.size() > 0) ? q[0] : '0;
         chk_all($sformatf("rnd%0d", c), m_ir, m_ov, m_do, q.size());
         if (flush) begin
            q.delete();
         end else begin
            if (m_ov && out_ready) void'(q.pop_front());
            if (m_ir && in_valid) q.push_back(DataI);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
